rvpipe_skid: RTL
================

// Module: rvpipe_skid
// PURPOSE
//  Parametrised successor to the plain reset-to-zero data flop: a DEPTH-stage, WIDTH-bit
//  valid/ready pipeline built from skid-buffered register slices, with a synchronous flush
//  and an occupancy count. Full throughput of 1 beat/cycle with every ready path registered.
//  Used to retime long interconnect paths between pipeline units and the LSU/IFU without
//  losing beats under backpressure.
// PARAMETERS
//  WIDTH    17  data bits per beat (>=1)
//  DEPTH    2   number of register slices (>=1); latency in cycles when unstalled
//  RST_VAL  0   reset value of all data registers (WIDTH bits)
// PORTS
//  clk         in   1               clock, all state updates on posedge
//  rst_l       in   1               asynchronous reset, active low
//  flush       in   1               synchronous flush: discard all beats in flight
//  din_valid   in   1               upstream beat valid
//  din         in   WIDTH           upstream data
//  din_ready   out  1               pipe can accept (registered, = ~skid_v of slice 0)
//  dout_valid  out  1               downstream beat valid (= main_v of last slice)
//  dout        out  WIDTH           downstream data (= main_d of last slice)
//  dout_ready  in   1               downstream accepts
//  count       out  $clog2(2*DEPTH+1)  beats currently held (main_v+skid_v, all slices)
// BEHAVIOUR
//  - Reset (rst_l=0, async): all main_v/skid_v=0, all main_d/skid_d=RST_VAL, count=0;
//    outputs: din_ready=1, dout_valid=0, dout=RST_VAL. Applies immediately, mid-transfer too;
//    in-flight beats are lost.
//  - Slice i has main (v,d) and skid (v,d). in_ready_i=~skid_v_i; out_valid_i=main_v_i;
//    slice i output feeds slice i+1 input; slice 0 input = din*, last output = dout*.
//  - accept_i = in_valid_i & in_ready_i;  take_i = main_v_i & out_ready_i.
//  - Per edge, if (~main_v_i | take_i): if skid_v_i {main<=skid; skid_v<=0}
//      else {main_v<=accept_i; if accept_i main_d<=in_d}.
//    Else (main held): if accept_i {skid_d<=in_d; skid_v<=1}.
//  - Beats never dropped, duplicated or reordered; data stable while dout_valid & ~dout_ready.
//  - Latency: beat accepted at edge N appears on dout after edge N+DEPTH-1 (dout_valid high
//    in cycle N+DEPTH) when no stall. Throughput 1 beat/cycle sustained.
//  - Capacity 2*DEPTH beats; din_ready=0 exactly when slice 0 skid is full.
//  - Flush (sync, highest priority after reset): at the edge, all valid bits <=0, count<=0;
//    din accepted in that cycle is discarded; a dout handshake in the flush cycle still
//    counts as delivered. Data regs keep value (not cleared).
//  - count: +1 on din accept, -1 on dout take, both same cycle -> unchanged; saturates by
//    construction at 2*DEPTH, never underflows. Must equal popcount of valid bits.
//  - No combinational path din_valid->din_ready or dout_ready->din_ready/dout_valid.
// TESTING
//  1 Reset: assert rst_l=0 mid-stream with 3 beats held -> next sample dout_valid=0,
//    din_ready=1, count=0, dout=RST_VAL, with no clk edge needed.
//  2 Stream, DEPTH=2, dout_ready=1: din=0x00001..0x00008 one per cycle -> dout same order,
//    first dout_valid 2 cycles after first accept, no bubbles, count steady at 2.
//  3 Backpressure, DEPTH=2: dout_ready=0, drive 6 beats -> first 4 accepted, din_ready=0
//    after 4th, count=4; release dout_ready -> 4 beats out in order, then remaining 2.
//  4 Simultaneous: count=2, din accept and dout take same cycle -> count stays 2.
//  5 Flush: 3 beats held, flush=1 with din_valid=1 -> next cycle count=0, dout_valid=0,
//    din_ready=1; flushed and flush-cycle din beats never appear on dout.
//  6 Random valid/ready (DEPTH=1,3,4; WIDTH=1,17,64), scoreboard vs reference FIFO ->
//    zero mismatches; assert din_ready==~skid_v[0] and count==popcount(valids) every cycle.

Source files
------------

// File: rtl/rvpipe_skid.sv
// DEPTH-stage valid/ready pipeline of skid-buffered register slices with a synchronous
// flush and an occupancy count. Every ready is registered, so it can retime long paths.
module rvpipe_skid #(
  parameter int               WIDTH   = 17,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           flush,
  input  logic                           din_valid,
  input  logic [WIDTH-1:0]               din,
  output logic                           din_ready,
  output logic                           dout_valid,
  output logic [WIDTH-1:0]               dout,
  input  logic                           dout_ready,
  output logic [$clog2(2*DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0] main_v;
  logic [DEPTH-1:0] skid_v;
  logic [WIDTH-1:0] main_d [DEPTH];
  logic [DEPTH-1:0] in_valid;
  logic [DEPTH-1:0] out_ready;
  logic [WIDTH-1:0] in_d   [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic             accept;
    logic             take;

    // Slice i sees slice i-1's main register as its upstream and slice i+1's skid as backpressure.
    if (gi == 0) begin : g_head
      assign in_valid[gi] = din_valid;
      assign in_d[gi]     = din;
    end else begin : g_link
      assign in_valid[gi] = main_v[gi-1];
      assign in_d[gi]     = main_d[gi-1];
    end

    if (gi == DEPTH-1) begin : g_tail
      assign out_ready[gi] = dout_ready;
    end else begin : g_chain
      assign out_ready[gi] = ~skid_v[gi+1];
    end

    assign accept = in_valid[gi] & ~skid_v_q;
    assign take   = main_v_q & out_ready[gi];

    always_comb begin
      main_v_d = main_v_q;
      skid_v_d = skid_v_q;
      main_d_d = main_d_q;
      skid_d_d = skid_d_q;
      if (flush) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end else if (!main_v_q || take) begin
        if (skid_v_q) begin
          main_v_d = 1'b1;
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end else begin
          main_v_d = accept;
          if (accept) main_d_d = in_d[gi];
        end
      end else if (accept) begin
        skid_v_d = 1'b1;
        skid_d_d = in_d[gi];
      end
    end

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
        main_d_q <= RST_VAL;
        skid_d_q <= RST_VAL;
      end else begin
        main_v_q <= main_v_d;
        skid_v_q <= skid_v_d;
        main_d_q <= main_d_d;
        skid_d_q <= skid_d_d;
      end
    end

    assign main_v[gi] = main_v_q;
    assign skid_v[gi] = skid_v_q;
    assign main_d[gi] = main_d_q;
  end

  assign din_ready  = ~skid_v[0];
  assign dout_valid = main_v[DEPTH-1];
  assign dout       = main_d[DEPTH-1];

  logic          beat_in;
  logic          beat_out;
  logic [CW-1:0] count_q, count_d;

  assign beat_in  = din_valid & din_ready;
  assign beat_out = dout_valid & dout_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({beat_in, beat_out})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule
